// File: rtl/axistream_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-stream producers onto one sink.
// One idle arbitration cycle per packet; LOCKED is a pure combinational pass-through.
module axistream_rr_packet_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_tvalid,
    output logic [NUM_SRC-1:0]            src_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_SRC-1:0]            src_tlast,
    output logic                          dest_tvalid,
    input  logic                          dest_tready,
    output logic [DATA_WIDTH-1:0]         dest_tdata,
    output logic                          dest_tlast,
    output logic [SEL_WIDTH-1:0]          dest_tid,
    output logic                          busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_next;
    logic [SEL_WIDTH-1:0]  gnt_idx, gnt_next;
    logic [SEL_WIDTH-1:0]  last_idx, last_next;
    logic [SEL_WIDTH-1:0]  scan_idx;
    logic                  found;
    logic                  sel_valid, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_idx == SEL_WIDTH'(i)) begin
                sel_valid = src_tvalid[i];
                sel_last  = src_tlast[i];
                sel_data  = src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Circular scan split in two passes: indices above last_idx first, then the wrap from 0.
    always_comb begin
        found    = 1'b0;
        scan_idx = last_idx;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (!found && src_tvalid[j] && (SEL_WIDTH'(j) > last_idx)) begin
                found    = 1'b1;
                scan_idx = SEL_WIDTH'(j);
            end
        end
        for (int j = 0; j < NUM_SRC; j++) begin
            if (!found && src_tvalid[j] && (SEL_WIDTH'(j) <= last_idx)) begin
                found    = 1'b1;
                scan_idx = SEL_WIDTH'(j);
            end
        end
    end

    always_comb begin
        state_next = state;
        gnt_next   = gnt_idx;
        last_next  = last_idx;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_next   = scan_idx;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (sel_valid && dest_tready && sel_last) begin
                    last_next  = gnt_idx;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last_idx <= SEL_WIDTH'(NUM_SRC - 1);
        end else begin
            state    <= state_next;
            gnt_idx  <= gnt_next;
            last_idx <= last_next;
        end
    end

    // Reset overrides everything so a half-sent packet cannot leak a beat in the reset cycle.
    always_comb begin
        src_tready  = '0;
        dest_tvalid = 1'b0;
        dest_tlast  = 1'b0;
        busy        = 1'b0;
        dest_tdata  = sel_data;
        dest_tid    = gnt_idx;
        if (!rst_n) begin
            dest_tid = '0;
        end else if (state == LOCKED) begin
            dest_tvalid = sel_valid;
            dest_tlast  = sel_last;
            busy        = 1'b1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt_idx == SEL_WIDTH'(i)) begin
                    src_tready[i] = dest_tready;
                end
            end
        end
    end

endmodule

// File: tb/tb_axistream_rr_packet_arbiter.sv
// Self-checking bench: vector table, directed packet sequences and random traffic
// compared against a packet-level round-robin reference model; plus a NUM_SRC=3 build.
module tb_axistream_rr_packet_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   svalid, slast, src_tready;
    logic [31:0]  sdata [4];
    logic [127:0] src_tdata;
    logic         dready, dest_tvalid, dest_tlast, busy;
    logic [31:0]  dest_tdata;
    logic [1:0]   dest_tid;

    logic         rst3_n;
    logic [2:0]   v3, l3, tready3;
    logic [95:0]  d3;
    logic         dv3, dl3, busy3;
    logic [31:0]  dd3;
    logic [1:0]   tid3;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) src_tdata[i*32 +: 32] = sdata[i];
    end

    axistream_rr_packet_arbiter #(.DATA_WIDTH(32), .NUM_SRC(4), .SEL_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_tvalid(svalid), .src_tready(src_tready), .src_tdata(src_tdata), .src_tlast(slast),
        .dest_tvalid(dest_tvalid), .dest_tready(dready), .dest_tdata(dest_tdata),
        .dest_tlast(dest_tlast), .dest_tid(dest_tid), .busy(busy)
    );

    axistream_rr_packet_arbiter #(.DATA_WIDTH(32), .NUM_SRC(3), .SEL_WIDTH(2)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .src_tvalid(v3), .src_tready(tready3), .src_tdata(d3), .src_tlast(l3),
        .dest_tvalid(dv3), .dest_tready(1'b1), .dest_tdata(dd3),
        .dest_tlast(dl3), .dest_tid(tid3), .busy(busy3)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        ready;
        logic [31:0] data1;
        logic [3:0]  e_tready;
        logic        e_valid;
        logic        e_last;
        logic [1:0]  e_tid;
        logic        e_busy;
        logic        chk_data;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [12];

    int tests = 0;
    int fails = 0;

    // Reference model: owner of the sink (-1 when idle), last served source, held tid.
    int m_owner = -1;
    int m_last  = 3;
    int m_tid   = 0;

    int  rem [4], len [4], beat [4];
    logic [7:0] tag [4];
    bit  hold [4], hs [4];
    bit  rnd_mode = 0;
    bit  prev_busy = 0;
    int  leak = 0;

    logic [1:0]  x_tid [$];
    logic [31:0] x_data [$];
    logic        x_last [$];
    int          glog [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        logic [3:0]  e_ready;
        logic        e_valid, e_last, e_busy;
        logic [1:0]  e_tid;
        logic [31:0] e_data;
        @(negedge clk);
        e_ready = '0; e_valid = 0; e_last = 0; e_busy = 0; e_data = '0;
        e_tid = 2'(m_tid);
        if (!rst_n) begin
            e_tid = 2'd0;
        end else if (m_owner >= 0) begin
            e_valid          = svalid[m_owner];
            e_last           = slast[m_owner];
            e_data           = sdata[m_owner];
            e_ready[m_owner] = dready;
            e_busy           = 1'b1;
            e_tid            = 2'(m_owner);
        end
        checkOutput("src_tready", 64'(src_tready), 64'(e_ready));
        checkOutput("dest_tvalid", 64'(dest_tvalid), 64'(e_valid));
        checkOutput("dest_tlast", 64'(dest_tlast), 64'(e_last));
        checkOutput("dest_tid", 64'(dest_tid), 64'(e_tid));
        checkOutput("busy", 64'(busy), 64'(e_busy));
        if (e_valid) checkOutput("dest_tdata", 64'(dest_tdata), 64'(e_data));
        for (int i = 0; i < 4; i++) hs[i] = src_tready[i] && svalid[i];
        if (src_tready[1] && m_owner == 2) leak++;
        if (dest_tvalid && dready) begin
            x_tid.push_back(dest_tid);
            x_data.push_back(dest_tdata);
            x_last.push_back(dest_tlast);
        end
        if (busy && !prev_busy) glog.push_back(int'(dest_tid));
        prev_busy = busy;
    endtask

    task automatic advance();
        bit got;
        @(posedge clk);
        if (!rst_n) begin
            m_owner = -1; m_last = 3; m_tid = 0;
        end else if (m_owner < 0) begin
            got = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!got && svalid[(m_last + k) % 4]) begin
                    got = 1;
                    m_owner = (m_last + k) % 4;
                    m_tid = m_owner;
                end
            end
        end else if (svalid[m_owner] && dready && slast[m_owner]) begin
            m_last = m_owner;
            m_owner = -1;
        end
        #1;
    endtask

    task automatic drive_gen();
        for (int i = 0; i < 4; i++) begin
            svalid[i] = (rem[i] > 0) && !hold[i];
            slast[i]  = (beat[i] == len[i] - 1);
            sdata[i]  = {tag[i], 8'h00, 4'(i), 4'h0, 4'(beat[i]), 4'h0};
        end
    endtask

    task automatic update_gen();
        for (int i = 0; i < 4; i++) begin
            if (hold[i]) hold[i] = 0;
            if (hs[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    rem[i]--;
                    tag[i] = rnd_mode ? 8'($urandom) : 8'h00;
                end else begin
                    beat[i]++;
                end
                hold[i] = rnd_mode && ($urandom_range(0, 3) == 0);
            end
            if (rnd_mode && rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                rem[i] = 1;
                len[i] = $urandom_range(1, 4);
                tag[i] = 8'($urandom);
            end
        end
    endtask

    task automatic applyStimulus();
        drive_gen();
        sample();
        advance();
        update_gen();
    endtask

    task automatic clear_logs();
        x_tid.delete(); x_data.delete(); x_last.delete(); glog.delete();
    endtask

    task automatic reset_gen();
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0; len[i] = 1; beat[i] = 0; tag[i] = 8'h00; hold[i] = 0; hs[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rr_order [5];
        int src, b, n;
        bit done;

        rst_n = 1'b0; dready = 1'b1; svalid = '0; slast = '0;
        for (int i = 0; i < 4; i++) sdata[i] = 32'hA0 + 32'(i);
        rst3_n = 1'b0; v3 = 3'b111; l3 = 3'b111;
        d3 = {32'h33, 32'h22, 32'h11};
        reset_gen();

        // rst, valid, last, ready, data1 | e_tready, e_valid, e_last, e_tid, e_busy, chk, e_data
        tbl[0]  = '{1'b0, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 4'hF, 4'hF, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 4'h0, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 4'h2, 4'h2, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 4'h2, 4'h2, 1'b1, 32'hDEADBEEF, 4'h2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[8]  = '{1'b1, 4'h0, 4'h0, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 4'hF, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 4'hF, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 4'hF, 4'h0, 1'b1, 32'h0,        4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0};

        for (int v = 0; v < 12; v++) begin
            rst_n = tbl[v].rst_n; svalid = tbl[v].valid; slast = tbl[v].last;
            dready = tbl[v].ready; sdata[1] = tbl[v].data1;
            sample();
            checkOutput($sformatf("vec%0d_tready", v), 64'(src_tready), 64'(tbl[v].e_tready));
            checkOutput($sformatf("vec%0d_tvalid", v), 64'(dest_tvalid), 64'(tbl[v].e_valid));
            checkOutput($sformatf("vec%0d_tlast", v), 64'(dest_tlast), 64'(tbl[v].e_last));
            checkOutput($sformatf("vec%0d_tid", v), 64'(dest_tid), 64'(tbl[v].e_tid));
            checkOutput($sformatf("vec%0d_busy", v), 64'(busy), 64'(tbl[v].e_busy));
            if (tbl[v].chk_data) checkOutput($sformatf("vec%0d_tdata", v), 64'(dest_tdata), 64'(tbl[v].e_data));
            advance();
        end
        rst_n = 1'b1;

        // Round robin with continuous 2-beat packets from every source
        clear_logs();
        dready = 1'b1;
        for (int i = 0; i < 4; i++) begin rem[i] = 100; len[i] = 2; end
        for (int c = 0; c < 15; c++) applyStimulus();
        reset_gen();
        rr_order = '{0, 1, 2, 3, 0};
        checkOutput("rr_grant_count", 64'(glog.size() >= 5), 64'd1);
        for (int g = 0; g < 5 && g < glog.size(); g++)
            checkOutput($sformatf("rr_grant%0d", g), 64'(glog[g]), 64'(rr_order[g]));
        checkOutput("rr_beat_count", 64'(x_tid.size()), 64'd10);
        for (int k = 0; k < 10 && k < x_tid.size(); k++) begin
            src = rr_order[k / 2]; b = k % 2;
            checkOutput($sformatf("rr_tid%0d", k), 64'(x_tid[k]), 64'(src));
            checkOutput($sformatf("rr_data%0d", k), 64'(x_data[k]), 64'((src << 12) | (b << 4)));
            checkOutput($sformatf("rr_last%0d", k), 64'(x_last[k]), 64'(b == 1));
        end

        // Source 2 locks a 4-beat packet under toggling backpressure while source 1 waits
        clear_logs();
        leak = 0;
        rem[2] = 1; len[2] = 4;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            dready = (c == 0) ? 1'b1 : 1'(c % 2);
            if (c == 1) begin rem[1] = 1; len[1] = 1; end
            applyStimulus();
            done = (c > 1) && rem[1] == 0 && rem[2] == 0 && m_owner < 0;
        end
        checkOutput("bp_done", 64'(done), 64'd1);
        checkOutput("bp_src1_tready_leak", 64'(leak), 64'd0);
        checkOutput("bp_beat_count", 64'(x_tid.size()), 64'd5);
        for (int k = 0; k < 4 && k < x_tid.size(); k++) begin
            checkOutput($sformatf("bp_tid%0d", k), 64'(x_tid[k]), 64'd2);
            checkOutput($sformatf("bp_data%0d", k), 64'(x_data[k]), 64'((2 << 12) | (k << 4)));
            checkOutput($sformatf("bp_last%0d", k), 64'(x_last[k]), 64'(k == 3));
        end
        if (x_tid.size() >= 5) checkOutput("bp_next_tid", 64'(x_tid[4]), 64'd1);
        checkOutput("bp_grants", 64'(glog.size()), 64'd2);
        if (glog.size() >= 2) checkOutput("bp_second_grant", 64'(glog[1]), 64'd1);

        // Reset in the middle of a 5-beat packet from source 0
        reset_gen();
        dready = 1'b1;
        rem[0] = 1; len[0] = 5;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            applyStimulus();
            done = (beat[0] == 2);
        end
        checkOutput("mr_reach_beat2", 64'(done), 64'd1);
        drive_gen();
        rst_n = 1'b0;
        sample();
        checkOutput("mr_rst_tvalid", 64'(dest_tvalid), 64'd0);
        checkOutput("mr_rst_tready", 64'(src_tready), 64'd0);
        checkOutput("mr_rst_busy", 64'(busy), 64'd0);
        advance();
        rst_n = 1'b1;
        beat[0] = 0; rem[0] = 1;
        clear_logs();
        done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            applyStimulus();
            done = rem[0] == 0 && m_owner < 0;
        end
        checkOutput("mr_done", 64'(done), 64'd1);
        checkOutput("mr_first_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
        checkOutput("mr_beat_count", 64'(x_tid.size()), 64'd5);
        for (int k = 0; k < 5 && k < x_tid.size(); k++) begin
            checkOutput($sformatf("mr_data%0d", k), 64'(x_data[k]), 64'(k << 4));
            checkOutput($sformatf("mr_last%0d", k), 64'(x_last[k]), 64'(k == 4));
        end

        // Random traffic: packet lengths, gaps, backpressure and occasional reset
        reset_gen();
        rnd_mode = 1;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            dready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 79) != 0);
            applyStimulus();
            if (!rst_n) begin
                n++;
                for (int i = 0; i < 4; i++) begin beat[i] = 0; hold[i] = 0; end
            end
            rst_n = 1'b1;
        end
        rnd_mode = 0;
        reset_gen();

        // Three-source build: full contention must rotate 0,1,2,0 and never show tid 3
        clear_logs();
        @(posedge clk);
        #1 rst3_n = 1'b1;
        prev_busy = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput("n3_tid_range", 64'(tid3 == 2'd3), 64'd0);
            if (busy3 && !prev_busy) glog.push_back(int'(tid3));
            prev_busy = busy3;
        end
        rr_order = '{0, 1, 2, 0, 1};
        checkOutput("n3_grant_count", 64'(glog.size() >= 4), 64'd1);
        for (int g = 0; g < 4 && g < glog.size(); g++)
            checkOutput($sformatf("n3_grant%0d", g), 64'(glog[g]), 64'(rr_order[g]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axistream_rr_packet_arbiter.md
Name: axistream_rr_packet_arbiter

Overview:
- Shares one AXI-stream sink (typically the input of a block-RAM AXI-stream FIFO) between NUM_SRC AXI-stream producers.
- Round-robin arbitration at packet granularity: once granted, a source owns the sink until its tlast beat transfers.
- Forwards the winning source index on dest_tid so downstream logic can demultiplex or tag packets.

Parameters:
- DATA_WIDTH, 32, tdata width per source.
- NUM_SRC, 4, number of requesting sources; legal range is 2 to 2**SEL_WIDTH.
- SEL_WIDTH, 2, width of the grant index and dest_tid.

Ports:
- clk  input  1  sole clock; all logic on the rising edge.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- src_tvalid  input  NUM_SRC  per-source tvalid; bit i belongs to source i.
- src_tready  output  NUM_SRC  per-source tready.
- src_tdata  input  NUM_SRC*DATA_WIDTH  flattened; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_tlast  input  NUM_SRC  per-source tlast.
- dest_tvalid  output  1  sink tvalid.
- dest_tready  input  1  sink tready.
- dest_tdata  output  DATA_WIDTH  sink tdata.
- dest_tlast  output  1  sink tlast.
- dest_tid  output  SEL_WIDTH  index of the currently granted source.
- busy  output  1  high while a packet is locked (state LOCKED).

Behaviour:
- State machine has two states, IDLE and LOCKED, plus registers gnt_idx[SEL_WIDTH-1:0] and last_idx[SEL_WIDTH-1:0].
- Reset (rst_n=0 at a rising edge):
  - state <= IDLE, gnt_idx <= 0, last_idx <= NUM_SRC-1, so source 0 has first priority.
  - While rst_n=0, all outputs are forced combinationally low: src_tready=0, dest_tvalid=0, dest_tlast=0, busy=0.
  - dest_tid reads 0 during and immediately after reset; dest_tdata is don't-care while dest_tvalid=0.
- Reset mid-packet abandons the packet. No beat transfers in the reset cycle, and the next packet starts from IDLE.
- IDLE:
  - src_tready=0 and dest_tvalid=0.
  - If any src_tvalid bit is high, select the first asserted index in circular order last_idx+1, last_idx+2, ... (mod NUM_SRC).
  - Register that index into gnt_idx and go to LOCKED.
  - If no bit is high, stay in IDLE.
- LOCKED (pure combinational pass-through of the granted source, no added register stage):
  - dest_tvalid = src_tvalid[gnt_idx]; dest_tdata and dest_tlast are taken from source gnt_idx.
  - src_tready[gnt_idx] = dest_tready; every other src_tready bit is 0.
  - dest_tid = gnt_idx; busy = 1.
  - When dest_tvalid && dest_tready && dest_tlast: last_idx <= gnt_idx, state <= IDLE.
- Latency and throughput:
  - Arbitration costs exactly one idle cycle per packet. A request seen in IDLE at edge N gives its first possible transfer in cycle N+1.
  - Peak throughput for L-beat packets is L/(L+1).
- The grant decision is sampled only in IDLE. A source that deasserts tvalid mid-packet keeps the lock; the sink simply sees dest_tvalid=0.
- Sources must not retract tvalid before a handshake (AXI rule). The arbiter does not check this.
- A single-beat packet (tvalid and tlast on the first beat) returns to IDLE after one transfer.
- A source that is the only requester is granted back-to-back, with one idle cycle between its packets.
- Fairness: with all sources continuously requesting, grants rotate 0,1,...,NUM_SRC-1,0,...
- Index arithmetic wraps modulo NUM_SRC, not 2**SEL_WIDTH. For example, with NUM_SRC=3 the next after index 2 is 0.
- src_tvalid bits at indices >= NUM_SRC do not exist; no out-of-range grant is possible.
- dest_tid is stable for the whole packet; it holds its last value in IDLE.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all src_tvalid=4'b1111 -> src_tready=0, dest_tvalid=0, busy=0 throughout. After release, the first grant is dest_tid=0.
- Round robin: 4 sources each present continuous 2-beat packets (data = 16'hS0B0 pattern, tlast on beat 2), dest_tready=1 -> dest_tid sequence 0,1,2,3,0. Each packet takes 3 cycles (1 idle + 2 beats), and no beats are interleaved.
- Packet lock under backpressure: grant source 2 with a 4-beat packet, toggle dest_tready 1,0,1,0,... while source 1 also requests -> all 4 beats of source 2 emerge in order with dest_tid=2 before source 3 or 1 is granted. src_tready[1]=0 throughout.
- Sparse requests and wrap: last_idx=3, only source 1 requests a single-beat packet 32'hDEADBEEF with tlast=1 -> granted one cycle later. Exactly one transfer with dest_tlast=1, then IDLE; the next scan starts at index 2.
- Mid-packet reset: source 0 is at beat 2 of 5 and rst_n drops for 1 cycle -> outputs are low in that cycle. Afterwards, source 0's next packet is granted from IDLE with dest_tid=0, and no stale beats appear.
- NUM_SRC=3, SEL_WIDTH=2 build: sources 0,1,2 all requesting -> grant order 0,1,2,0. dest_tid never equals 3.
